// File: rtl/avmm_wr_ack_word_to_burst_pkg.sv
// Shared constants and types for the word-to-burst write-ack converter.
// The board packages are declared here too, so the slice is self-contained.
package local_mem_cfg_pkg;
  localparam int LOCAL_MEM_BURST_CNT_WIDTH = 7;
endpackage

package dc_bsp_pkg;
  import local_mem_cfg_pkg::*;
  localparam int WR_ACK_BURST_FIFO_DEPTH = 16;
  typedef logic [LOCAL_MEM_BURST_CNT_WIDTH-1:0] burstcnt_t;
endpackage

package avmm_wr_ack_word_to_burst_pkg;
  import local_mem_cfg_pkg::*;
  import dc_bsp_pkg::*;

  localparam int BC_W               = LOCAL_MEM_BURST_CNT_WIDTH;
  localparam int FIFO_DEPTH_DEFAULT = WR_ACK_BURST_FIFO_DEPTH;

  // The occupancy counter must be able to represent DEPTH itself.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/avmm_wr_ack_word_to_burst_if.sv
// Bus bundle for the write-ack converter: AVMM write beats, word acks and burst acks.
// err_sticky_out exists only when AVMM_WR_ACK_W2B_ERR_EN is defined.
interface avmm_wr_ack_word_to_burst_if
  import avmm_wr_ack_word_to_burst_pkg::*;
#(
  parameter int W = BC_W
) ();
  logic         avmm_waitreq;
  logic         avmm_wr;
  logic [W-1:0] avmm_burstcnt;
  logic         per_word_write_ack_in;
  logic         wr_stall_out;
  logic         per_burst_write_ack_out;
  logic [W-1:0] burstcnt_out;
`ifdef AVMM_WR_ACK_W2B_ERR_EN
  logic         err_sticky_out;

  modport master (
    output avmm_waitreq, avmm_wr, avmm_burstcnt, per_word_write_ack_in,
    input  wr_stall_out, per_burst_write_ack_out, burstcnt_out, err_sticky_out
  );
  modport slave (
    input  avmm_waitreq, avmm_wr, avmm_burstcnt, per_word_write_ack_in,
    output wr_stall_out, per_burst_write_ack_out, burstcnt_out, err_sticky_out
  );
`else
  modport master (
    output avmm_waitreq, avmm_wr, avmm_burstcnt, per_word_write_ack_in,
    input  wr_stall_out, per_burst_write_ack_out, burstcnt_out
  );
  modport slave (
    input  avmm_waitreq, avmm_wr, avmm_burstcnt, per_word_write_ack_in,
    output wr_stall_out, per_burst_write_ack_out, burstcnt_out
  );
`endif
endinterface

// File: rtl/avmm_wr_ack_burstcnt_fifo.sv
// Show-ahead synchronous FIFO of burst lengths with registered occupancy count.
// Push and pop in the same cycle are both honoured.
module avmm_wr_ack_burstcnt_fifo
  import avmm_wr_ack_word_to_burst_pkg::*;
#(
  parameter int W     = BC_W,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/avmm_wr_ack_word_to_burst.sv
// Converts per-word write acks back into one ack per completed AVMM write burst.
// Define AVMM_WR_ACK_W2B_ERR_EN to add the sticky protocol-error output.
module avmm_wr_ack_word_to_burst
  import avmm_wr_ack_word_to_burst_pkg::*;
#(
  parameter int AVMM_BURSTCNT_WIDTH = BC_W,
  parameter int BURST_FIFO_DEPTH    = FIFO_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  avmm_wr_ack_word_to_burst_if.slave   bus
);
  localparam int W = AVMM_BURSTCNT_WIDTH;

  logic [W-1:0] beat_cnt_q, beat_cnt_d;
  logic [W-1:0] bc_lat_q, bc_lat_d;
  logic [W-1:0] ack_cnt_q, ack_cnt_d;
  logic [W-1:0] bc_out_q, bc_out_d;
  logic         pulse_q, pulse_d;
  logic [W-1:0] head, bc_in;
  logic         full, empty, accept, first, push, ack_hit, pop;

  // A zero burst length is handled as a single-beat burst.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] bc);
    return (bc == '0) ? W'(1) : bc;
  endfunction

  assign accept  = bus.avmm_wr && !bus.avmm_waitreq;
  assign first   = accept && (beat_cnt_q == '0);
  assign bc_in   = sanitize(bus.avmm_burstcnt);
  assign push    = first && !full;
  assign ack_hit = bus.per_word_write_ack_in && !empty;
  assign pop     = ack_hit && ((ack_cnt_q + W'(1)) == head);

  avmm_wr_ack_burstcnt_fifo #(
    .W     (W),
    .DEPTH (BURST_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (bc_in),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    bc_lat_d   = bc_lat_q;
    if (first) begin
      bc_lat_d   = bc_in;
      beat_cnt_d = (bc_in == W'(1)) ? '0 : W'(1);
    end else if (accept) begin
      beat_cnt_d = (beat_cnt_q == bc_lat_q - W'(1)) ? '0 : beat_cnt_q + W'(1);
    end
  end

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    pulse_d   = 1'b0;
    bc_out_d  = bc_out_q;
    if (pop) begin
      ack_cnt_d = '0;
      pulse_d   = 1'b1;
      bc_out_d  = head;
    end else if (ack_hit) begin
      ack_cnt_d = ack_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
      bc_lat_q   <= '0;
      ack_cnt_q  <= '0;
      bc_out_q   <= '0;
      pulse_q    <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      bc_lat_q   <= bc_lat_d;
      ack_cnt_q  <= ack_cnt_d;
      bc_out_q   <= bc_out_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus.wr_stall_out            = full && (beat_cnt_q == '0);
  assign bus.per_burst_write_ack_out = pulse_q;
  assign bus.burstcnt_out            = bc_out_q;

`ifdef AVMM_WR_ACK_W2B_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((first && full) || (bus.per_word_write_ack_in && empty) ||
        (first && bus.avmm_burstcnt == '0))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.err_sticky_out = err_q;
`endif
endmodule
